// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor.
//   pll_sup_state_e : supervisor FSM states
//   cnt_width()     : width of the shared phase counter, large enough to
//                     count up to the longest phase minus one
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    FILTER    = 3'd2,
    SEQUENCE  = 3'd3,
    RUN       = 3'd4
  } pll_sup_state_e;

  // One counter is reused by every phase, so it is sized for the longest one.
  function automatic int cnt_width(input int lock_timeout, input int lock_filter,
                                   input int stage_delay, input int pll_rst_cycles);
    int m;
    m = lock_timeout;
    if (lock_filter > m)    m = lock_filter;
    if (stage_delay > m)    m = stage_delay;
    if (pll_rst_cycles > m) m = pll_rst_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Bundle of PLL-side and fabric-side signals of the lock supervisor.
//   locked        : PLL lock flag (asynchronous to refclk)
//   sw_relock     : single-cycle request to reset the PLL and re-sequence
//   pll_rst       : reset to the PLL, active-high
//   rst_out       : staged downstream resets, active-high, bit i = stage i
//   all_ready     : high while the supervisor is in RUN
//   relock_count  : saturating count of lock-loss events
//   timeout_count : saturating count of lock timeouts
// slave = supervisor side, master = PLL/fabric/stimulus side.
interface pll_lock_supervisor_if #(
  parameter int NUM_STAGES = 3,
  parameter int CNT_W      = 8
);
  logic                  locked;
  logic                  sw_relock;
  logic                  pll_rst;
  logic [NUM_STAGES-1:0] rst_out;
  logic                  all_ready;
  logic [CNT_W-1:0]      relock_count;
  logic [CNT_W-1:0]      timeout_count;

  modport slave (
    input  locked, sw_relock,
    output pll_rst, rst_out, all_ready, relock_count, timeout_count
  );

  modport master (
    output locked, sw_relock,
    input  pll_rst, rst_out, all_ready, relock_count, timeout_count
  );
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit.
//   clk : destination clock
//   rst : synchronous active-high reset, loads RST_VAL into both flops
//   d   : asynchronous input
//   q   : synchronized output, two clk cycles of latency
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor and staged reset sequencer, clocked by the free-running
// reference clock so it keeps working while the PLL output is absent.
//   refclk : reference clock, the only clock in the block
//   rst    : synchronous active-high reset
//   bus    : slave side of pll_lock_supervisor_if (locked/sw_relock in,
//            pll_rst/rst_out/all_ready/relock_count/timeout_count out)
// Flow: PLL_RESET -> WAIT_LOCK -> FILTER -> SEQUENCE -> RUN. A timeout in
// WAIT_LOCK pulses the PLL reset again; a filtered lock loss in SEQUENCE/RUN
// drops back to WAIT_LOCK without touching pll_rst.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int NUM_STAGES     = 3,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int LOCK_FILTER    = 1024,
  parameter int STAGE_DELAY    = 256,
  parameter int LOSS_FILTER    = 4,
  parameter int CNT_W          = 8
) (
  input  logic                   refclk,
  input  logic                   rst,
  pll_lock_supervisor_if.slave   bus
);

  localparam int CNT_BITS = cnt_width(LOCK_TIMEOUT, LOCK_FILTER, STAGE_DELAY, PLL_RST_CYCLES);
  localparam int STG_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int LOSS_W   = $clog2(LOSS_FILTER + 1);

  localparam logic [2:0] ST_PLL_RESET = PLL_RESET;
  localparam logic [2:0] ST_WAIT_LOCK = WAIT_LOCK;
  localparam logic [2:0] ST_FILTER    = FILTER;
  localparam logic [2:0] ST_SEQUENCE  = SEQUENCE;
  localparam logic [2:0] ST_RUN       = RUN;

  logic                  locked_s;
  logic [2:0]            state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [STG_W-1:0]      stage_q, stage_d;
  logic [LOSS_W-1:0]     loss_q, loss_d;
  logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
  logic                  pll_rst_q, pll_rst_d;
  logic                  all_ready_q, all_ready_d;
  logic [CNT_W-1:0]      relock_q, relock_d;
  logic [CNT_W-1:0]      timeout_q, timeout_d;
  logic                  in_seq_run;
  logic                  loss_hit;

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (bus.locked),
    .q   (locked_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    rst_out_d = rst_out_q;
    relock_d  = relock_q;
    timeout_d = timeout_q;

    // Consecutive-low counter only runs once the fabric is (being) released.
    in_seq_run = (state_q == ST_SEQUENCE) || (state_q == ST_RUN);
    loss_d     = (in_seq_run && !locked_s) ? loss_q + 1'b1 : '0;
    loss_hit   = in_seq_run && !locked_s && (loss_q == LOSS_W'(LOSS_FILTER - 1));

    if (bus.sw_relock && (state_q != ST_PLL_RESET)) begin
      state_d   = ST_PLL_RESET;
      cnt_d     = '0;
      stage_d   = '0;
      loss_d    = '0;
      rst_out_d = '1;
    end else if (loss_hit) begin
      state_d   = ST_WAIT_LOCK;
      cnt_d     = '0;
      stage_d   = '0;
      loss_d    = '0;
      rst_out_d = '1;
      if (relock_q != '1) relock_d = relock_q + 1'b1;
    end else begin
      case (state_q)
        ST_PLL_RESET: begin
          rst_out_d = '1;
          if (cnt_q == CNT_BITS'(PLL_RST_CYCLES - 1)) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = ST_FILTER;
            cnt_d   = '0;
          end else if (cnt_q == CNT_BITS'(LOCK_TIMEOUT - 1)) begin
            state_d = ST_PLL_RESET;
            cnt_d   = '0;
            if (timeout_q != '1) timeout_d = timeout_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_FILTER: begin
          // Any low cycle restarts both the filter and the timeout window.
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == CNT_BITS'(LOCK_FILTER - 1)) begin
            state_d = ST_SEQUENCE;
            cnt_d   = '0;
            stage_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_SEQUENCE: begin
          if (cnt_q == CNT_BITS'(STAGE_DELAY - 1)) begin
            cnt_d     = '0;
            rst_out_d = rst_out_q & ~(NUM_STAGES'(1) << stage_q);
            if (stage_q == STG_W'(NUM_STAGES - 1)) state_d = ST_RUN;
            else                                   stage_d = stage_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          rst_out_d = '0;
        end
        default: begin
          state_d   = ST_PLL_RESET;
          cnt_d     = '0;
          stage_d   = '0;
          rst_out_d = '1;
        end
      endcase
    end

    pll_rst_d   = (state_d == ST_PLL_RESET);
    // Registered decode of the current state: lags RUN entry/exit by a cycle.
    all_ready_d = (state_q == ST_RUN);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= ST_PLL_RESET;
      cnt_q       <= '0;
      stage_q     <= '0;
      loss_q      <= '0;
      rst_out_q   <= '1;
      pll_rst_q   <= 1'b1;
      all_ready_q <= 1'b0;
      relock_q    <= '0;
      timeout_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stage_q     <= stage_d;
      loss_q      <= loss_d;
      rst_out_q   <= rst_out_d;
      pll_rst_q   <= pll_rst_d;
      all_ready_q <= all_ready_d;
      relock_q    <= relock_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.pll_rst       = pll_rst_q;
  assign bus.rst_out       = rst_out_q;
  assign bus.all_ready     = all_ready_q;
  assign bus.relock_count  = relock_q;
  assign bus.timeout_count = timeout_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed scenarios plus a
// randomized segment, every cycle compared against a phase/elapsed-time model.
module tb_pll_lock_supervisor;
  localparam int NS   = 3;
  localparam int PRC  = 4;
  localparam int TO   = 20;
  localparam int LF   = 8;
  localparam int SD   = 5;
  localparam int LOSS = 3;
  localparam int CW   = 8;

  localparam int P_PR = 0, P_WAIT = 1, P_FILT = 2, P_SEQ = 3, P_RUN = 4;

  logic refclk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  pll_lock_supervisor_if #(.NUM_STAGES(NS), .CNT_W(CW)) bus ();

  pll_lock_supervisor #(
    .NUM_STAGES(NS), .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(TO), .LOCK_FILTER(LF),
    .STAGE_DELAY(SD), .LOSS_FILTER(LOSS), .CNT_W(CW)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // Reference model: phase name, edges spent in the phase, lock history.
  int m_phase, m_t, m_low, m_rc, m_tc;
  bit m_h0, m_h1, m_ready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit sw, input bit lk);
    bit ls, sr;
    int low;
    if (r) begin
      m_phase = P_PR; m_t = 0; m_low = 0; m_rc = 0; m_tc = 0;
      m_h0 = 0; m_h1 = 0; m_ready = 0;
    end else begin
      ls      = m_h1;
      m_ready = (m_phase == P_RUN);
      sr      = (m_phase == P_SEQ) || (m_phase == P_RUN);
      low     = (sr && !ls) ? m_low + 1 : 0;
      m_low   = low;
      if (sw && m_phase != P_PR) begin
        m_phase = P_PR; m_t = 0; m_low = 0;
      end else if (sr && low >= LOSS) begin
        m_phase = P_WAIT; m_t = 0; m_low = 0;
        if (m_rc < 255) m_rc++;
      end else begin
        case (m_phase)
          P_PR:   begin m_t++; if (m_t == PRC) begin m_phase = P_WAIT; m_t = 0; end end
          P_WAIT: if (ls) begin m_phase = P_FILT; m_t = 0; end
                  else begin
                    m_t++;
                    if (m_t == TO) begin m_phase = P_PR; m_t = 0; if (m_tc < 255) m_tc++; end
                  end
          P_FILT: if (!ls) begin m_phase = P_WAIT; m_t = 0; end
                  else begin m_t++; if (m_t == LF) begin m_phase = P_SEQ; m_t = 0; end end
          P_SEQ:  begin m_t++; if (m_t == NS * SD) m_phase = P_RUN; end
          default: ;
        endcase
      end
      m_h1 = m_h0;
      m_h0 = lk;
    end
  endtask

  // Stage i is released once (i+1)*STAGE_DELAY edges have elapsed in SEQUENCE.
  function automatic logic [NS-1:0] exp_rst_out();
    logic [NS-1:0] v;
    v = '1;
    if (m_phase == P_RUN) v = '0;
    else if (m_phase == P_SEQ)
      for (int i = 0; i < NS; i++)
        if (m_t >= (i + 1) * SD) v = v & ~(NS'(1) << i);
    return v;
  endfunction

  task automatic tick();
    @(posedge refclk);
    model_step(rst, bus.sw_relock, bus.locked);
    cyc++;
    #1;
    chk("pll_rst",     32'(bus.pll_rst),       32'(m_phase == P_PR));
    chk("rst_out",     32'(bus.rst_out),       32'(exp_rst_out()));
    chk("all_ready",   32'(bus.all_ready),     32'(m_ready));
    chk("relock_cnt",  32'(bus.relock_count),  32'(m_rc));
    chk("timeout_cnt", 32'(bus.timeout_count), 32'(m_tc));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  int rc_before;

  initial begin
    rst = 1'b1; bus.locked = 1'b0; bus.sw_relock = 1'b0;
    m_phase = P_PR; m_t = 0; m_low = 0; m_rc = 0; m_tc = 0;
    m_h0 = 0; m_h1 = 0; m_ready = 0;
    tick();
    chk("rst_pll_rst", 32'(bus.pll_rst), 32'd1);
    chk("rst_rst_out", 32'(bus.rst_out), 32'd7);
    chk("rst_ready",   32'(bus.all_ready), 32'd0);

    // Nominal bring-up with lock present from reset release.
    bus.locked = 1'b1;
    do_reset();
    ticks(28);
    chk("nom_released", 32'(bus.rst_out), 32'd0);
    chk("nom_ready_lag", 32'(bus.all_ready), 32'd0);
    tick();
    chk("nom_ready", 32'(bus.all_ready), 32'd1);

    // Timeout retry: no lock at all.
    bus.locked = 1'b0;
    do_reset();
    ticks(72);
    chk("tmo_count", 32'(bus.timeout_count), 32'd3);
    chk("tmo_rst_out", 32'(bus.rst_out), 32'd7);

    // One-cycle glitch inside FILTER delays the first release by the refilter.
    bus.locked = 1'b1;
    do_reset();
    ticks(7);
    bus.locked = 1'b0; tick();
    bus.locked = 1'b1;
    ticks(15);
    chk("glitch_hold", 32'(bus.rst_out), 32'd7);
    tick();
    chk("glitch_rel0", 32'(bus.rst_out), 32'd6);

    // Loss in RUN: 2-cycle pulse filtered, 3-cycle pulse detected.
    do_reset();
    ticks(30);
    bus.locked = 1'b0; ticks(2);
    bus.locked = 1'b1; ticks(5);
    chk("short_ready", 32'(bus.all_ready), 32'd1);
    chk("short_rc",    32'(bus.relock_count), 32'd0);
    bus.locked = 1'b0; ticks(3);
    bus.locked = 1'b1; tick();
    chk("loss_before", 32'(bus.rst_out), 32'd0);
    tick();
    chk("loss_rst_out", 32'(bus.rst_out), 32'd7);
    chk("loss_rc",      32'(bus.relock_count), 32'd1);
    ticks(40);
    chk("reseq_ready", 32'(bus.all_ready), 32'd1);

    // sw_relock in RUN.
    bus.sw_relock = 1'b1; tick(); bus.sw_relock = 1'b0;
    chk("sw_pll_rst", 32'(bus.pll_rst), 32'd1);
    chk("sw_rst_out", 32'(bus.rst_out), 32'd7);
    tick();
    chk("sw_ready", 32'(bus.all_ready), 32'd0);
    ticks(2);
    chk("sw_pll_hold", 32'(bus.pll_rst), 32'd1);
    tick();
    chk("sw_pll_done", 32'(bus.pll_rst), 32'd0);

    // sw_relock on the same edge as a lock-loss detection.
    ticks(40);
    rc_before = m_rc;
    bus.locked = 1'b0; ticks(3);
    bus.locked = 1'b1; tick();
    bus.sw_relock = 1'b1; tick(); bus.sw_relock = 1'b0;
    chk("swloss_rc",  32'(bus.relock_count), 32'(rc_before));
    chk("swloss_pll", 32'(bus.pll_rst), 32'd1);

    // Randomized segments: lock runs, short/long drops, sporadic sw_relock/rst.
    for (int seg = 0; seg < 150; seg++) begin
      int kind, len;
      kind = int'($urandom_range(0, 9));
      if (kind <= 5)      begin bus.locked = 1'b1; len = int'($urandom_range(5, 40)); end
      else if (kind <= 8) begin bus.locked = 1'b0; len = int'($urandom_range(1, 5)); end
      else                begin bus.locked = 1'b0; len = int'($urandom_range(20, 60)); end
      for (int k = 0; k < len; k++) begin
        bus.sw_relock = ($urandom_range(0, 99) == 0);
        rst           = ($urandom_range(0, 299) == 0);
        tick();
      end
    end
    bus.sw_relock = 1'b0; rst = 1'b0;

    // Saturation: 300 lock losses, each caught during SEQUENCE.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      bus.locked = 1'b1; ticks(20);
      bus.locked = 1'b0; ticks(5);
    end
    chk("sat_rc", 32'(bus.relock_count), 32'd255);

    // Reset in the middle of SEQUENCE.
    bus.locked = 1'b1; ticks(15);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_pll",   32'(bus.pll_rst), 32'd1);
    chk("midrst_out",   32'(bus.rst_out), 32'd7);
    chk("midrst_ready", 32'(bus.all_ready), 32'd0);
    chk("midrst_rc",    32'(bus.relock_count), 32'd0);
    chk("midrst_tc",    32'(bus.timeout_count), 32'd0);
    ticks(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
